// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_seq
// Purpose  : Sequential RV64M multiply/divide unit using a shared 64-iteration
//            shift-add / restoring-divide datapath with sign correction.
// Revision : 1.0
// ============================================================================
module muldiv_seq (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic [2:0]  func_i,
    input  logic        word_i,
    input  logic [63:0] a_i,
    input  logic [63:0] b_i,
    input  logic        flush_i,
    output logic        ready_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [63:0] c_o
);

    localparam logic [1:0] C_IDLE = 2'd0;
    localparam logic [1:0] C_BUSY = 2'd1;
    localparam logic [1:0] C_FIX  = 2'd2;
    localparam logic [1:0] C_DONE = 2'd3;

    localparam logic [63:0] C_MIN64 = 64'h8000_0000_0000_0000;

    logic [1:0]   state_q, state_d;
    logic         done_q;
    logic [5:0]   cnt_q;
    logic [2:0]   func_q;
    logic         word_q, sa_q, sb_q;
    logic [63:0]  bmag_q, hi_q, lo_q, c_q;
    logic [63:0]  hi_d, lo_d;

    logic         w_accept, w_word_eff, w_a_signed, w_b_signed, w_sa, w_sb;
    logic         w_div_zero, w_ovf, w_special;
    logic [63:0]  w_a_prep, w_b_prep, w_a_mag, w_b_mag, w_spec_raw, w_spec_res;
    logic [64:0]  w_sum, w_shift, w_trial;
    logic [127:0] w_prod, w_prod_s;
    logic [63:0]  w_quo, w_rem, w_fix_raw, w_fix_res;

    // ---------------- operand preparation at accept ----------------
    always_comb begin
        w_word_eff = word_i & ((func_i == 3'b000) | func_i[2]);
        w_a_signed = ~(func_i[0] & (func_i[1] | func_i[2]));
        w_b_signed = w_a_signed & (func_i != 3'b010);
        w_a_prep   = a_i;
        w_b_prep   = b_i;
        if (w_word_eff) begin
            if (func_i[2] && func_i[0]) begin
                w_a_prep = {32'b0, a_i[31:0]};
                w_b_prep = {32'b0, b_i[31:0]};
            end else begin
                w_a_prep = {{32{a_i[31]}}, a_i[31:0]};
                w_b_prep = {{32{b_i[31]}}, b_i[31:0]};
            end
        end
        w_sa    = w_a_signed & w_a_prep[63];
        w_sb    = w_b_signed & w_b_prep[63];
        w_a_mag = w_sa ? -w_a_prep : w_a_prep;
        w_b_mag = w_sb ? -w_b_prep : w_b_prep;

        w_div_zero = func_i[2] & (w_b_prep == 64'd0);
        if (w_word_eff)
            w_ovf = func_i[2] & ~func_i[0] & (a_i[31:0] == 32'h8000_0000)
                    & (b_i[31:0] == 32'hFFFF_FFFF);
        else
            w_ovf = func_i[2] & ~func_i[0] & (a_i == C_MIN64) & (b_i == {64{1'b1}});
        w_special = w_div_zero | w_ovf;

        // Remainder-type ops have func[1] set.
        if (w_div_zero)
            w_spec_raw = func_i[1] ? w_a_prep : {64{1'b1}};
        else
            w_spec_raw = func_i[1] ? 64'd0 : w_a_prep;
        w_spec_res = w_word_eff ? {{32{w_spec_raw[31]}}, w_spec_raw[31:0]} : w_spec_raw;
    end

    // ---------------- iteration step ----------------
    always_comb begin
        w_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, bmag_q} : 65'd0);
        w_shift = {hi_q, lo_q[63]};
        w_trial = w_shift - {1'b0, bmag_q};
        if (func_q[2]) begin
            if (!w_trial[64]) begin
                hi_d = w_trial[63:0];
                lo_d = {lo_q[62:0], 1'b1};
            end else begin
                hi_d = w_shift[63:0];
                lo_d = {lo_q[62:0], 1'b0};
            end
        end else begin
            hi_d = w_sum[64:1];
            lo_d = {w_sum[0], lo_q[63:1]};
        end
    end

    // ---------------- sign correction and result select ----------------
    always_comb begin
        w_prod   = {hi_q, lo_q};
        w_prod_s = (sa_q ^ sb_q) ? -w_prod : w_prod;
        w_quo    = (sa_q ^ sb_q) ? -lo_q : lo_q;
        w_rem    = sa_q ? -hi_q : hi_q;
        case (func_q)
            3'b000:                 w_fix_raw = w_prod_s[63:0];
            3'b001, 3'b010, 3'b011: w_fix_raw = w_prod_s[127:64];
            3'b100, 3'b101:         w_fix_raw = w_quo;
            default:                w_fix_raw = w_rem;
        endcase
        w_fix_res = word_q ? {{32{w_fix_raw[31]}}, w_fix_raw[31:0]} : w_fix_raw;
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= C_IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_d == C_DONE);
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = C_IDLE;
        end else begin
            case (state_q)
                C_IDLE:  if (start_i) state_d = w_special ? C_DONE : C_BUSY;
                C_BUSY:  if (cnt_q == 6'd63) state_d = C_FIX;
                C_FIX:   state_d = C_DONE;
                default: state_d = C_IDLE;
            endcase
        end
    end

    always_comb begin
        ready_o  = (state_q == C_IDLE);
        busy_o   = (state_q != C_IDLE);
        done_o   = done_q;
        c_o      = c_q;
        w_accept = (state_q == C_IDLE) & start_i & ~flush_i;
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q  <= 6'd0;
            func_q <= 3'd0;
            word_q <= 1'b0;
            sa_q   <= 1'b0;
            sb_q   <= 1'b0;
            bmag_q <= 64'd0;
            hi_q   <= 64'd0;
            lo_q   <= 64'd0;
            c_q    <= 64'd0;
        end else if (w_accept) begin
            cnt_q  <= 6'd0;
            func_q <= func_i;
            word_q <= w_word_eff;
            sa_q   <= w_sa;
            sb_q   <= w_sb;
            bmag_q <= w_b_mag;
            hi_q   <= 64'd0;
            lo_q   <= w_a_mag;
            if (w_special)
                c_q <= w_spec_res;
        end else if (state_q == C_BUSY) begin
            cnt_q <= cnt_q + 6'd1;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
        end else if (state_q == C_FIX && !flush_i) begin
            c_q <= w_fix_res;
        end
    end

endmodule
`default_nettype wire
